// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port BRAM arbiter.
// No logic: state/owner encodings, default widths and a counter-width helper.
// Nothing here carries flow control.
package bram_port_arbiter_pkg;

  // Default geometry of the IO and DC BRAMs this arbiter sits in front of.
  localparam int IO_BRAM_ADDR_SIZE_BITS_NB = 32;
  localparam int IO_BRAM_WORD_SIZE_BITS_NB = 32;
  localparam int DC_BRAM_ADDR_SIZE_BITS_NB = 32;
  localparam int DC_BRAM_WORD_SIZE_BITS_NB = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_P0   = 2'b01,
    OWNER_P1   = 2'b10
  } owner_e;

  // Width of a counter that must hold 0..max_wait (at least one bit).
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Read-return tagger: delays a valid bit plus the issuing port id.
// Latency DEPTH cycles from in_vld to out_vld.
// No backpressure: shifts every cycle, cleared by synchronous reset.
module bram_port_arbiter_rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic in_vld,
  input  logic in_tag,
  output logic out_vld,
  output logic out_tag
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] tag_q;

  // Shift valid+tag one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      tag_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between the loader (port 0) and the compute engine (port 1).
// Grant 1 cycle after req; BRAM signals combinational from owner; rvalid RD_LATENCY after read.
// Owner holds until it drops req (no preemption); a loser simply waits with req held high.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = IO_BRAM_ADDR_SIZE_BITS_NB,
  parameter int DATA_W     = IO_BRAM_WORD_SIZE_BITS_NB,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 1024
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              req0_i,
  input  logic              req1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  input  logic              en0_i,
  input  logic              en1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_dout_o,
  output logic              bram_we_o,
  input  logic [DATA_W-1:0] bram_din_i,
  output logic [1:0]        owner_o,
  output logic              starve_o,
  output logic              proto_err_o
);

  localparam int         WAIT_W     = wait_cnt_width(MAX_WAIT);
  localparam logic [1:0] DRAIN_INIT = 2'(RD_LATENCY - 1);

  arb_state_e        state;
  logic              last_owner;  // 0: port 0 owned last, 1: port 1
  logic [1:0]        drain_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              waiting;
  logic              grant_now;
  logic              rd_push;
  logic              tag_vld;
  logic              tag_port;

  // Arbitration FSM: round-robin on ties, hold while req stays high, drain before re-arbitrating.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
      drain_cnt  <= '0;
      gnt0_o     <= 1'b0;
      gnt1_o     <= 1'b0;
      owner_o    <= OWNER_NONE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (req0_i && (!req1_i || last_owner)) begin
            state   <= ARB_OWN0;
            gnt0_o  <= 1'b1;
            owner_o <= OWNER_P0;
          end else if (req1_i) begin
            state   <= ARB_OWN1;
            gnt1_o  <= 1'b1;
            owner_o <= OWNER_P1;
          end
        end
        ARB_OWN0: begin
          if (!req0_i) begin
            state      <= ARB_DRAIN;
            gnt0_o     <= 1'b0;
            owner_o    <= OWNER_NONE;
            last_owner <= 1'b0;
            drain_cnt  <= DRAIN_INIT;
          end
        end
        ARB_OWN1: begin
          if (!req1_i) begin
            state      <= ARB_DRAIN;
            gnt1_o     <= 1'b0;
            owner_o    <= OWNER_NONE;
            last_owner <= 1'b1;
            drain_cnt  <= DRAIN_INIT;
          end
        end
        ARB_DRAIN: begin
          if (drain_cnt == 2'd0) state <= ARB_IDLE;
          else                   drain_cnt <= drain_cnt - 2'd1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // BRAM mux follows the current owner; writes are killed as soon as reset is asserted.
  always_comb begin
    bram_addr_o = '0;
    bram_dout_o = '0;
    bram_we_o   = 1'b0;
    if (gnt0_o) begin
      bram_addr_o = addr0_i;
      bram_dout_o = wdata0_i;
      bram_we_o   = en0_i & we0_i & ResetN;
    end else if (gnt1_o) begin
      bram_addr_o = addr1_i;
      bram_dout_o = wdata1_i;
      bram_we_o   = en1_i & we1_i & ResetN;
    end
  end

  // Only granted reads are tagged; ungranted strobes never reach the pipe.
  assign rd_push = (gnt0_o & en0_i & ~we0_i) | (gnt1_o & en1_i & ~we1_i);

  bram_port_arbiter_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .in_vld  (rd_push),
    .in_tag  (gnt1_o),
    .out_vld (tag_vld),
    .out_tag (tag_port)
  );

  assign rvalid0_o = tag_vld & ~tag_port;
  assign rvalid1_o = tag_vld &  tag_port;
  assign rdata0_o  = bram_din_i;
  assign rdata1_o  = bram_din_i;

  // Starvation counter: counts while the non-owner waits, saturates, clears when a grant is issued.
  assign waiting   = (gnt0_o & req1_i) | (gnt1_o & req0_i);
  assign grant_now = (state == ARB_IDLE) & (req0_i | req1_i);

  always_comb begin
    wait_nxt = wait_cnt;
    if (grant_now)                                      wait_nxt = '0;
    else if (waiting && wait_cnt != WAIT_W'(MAX_WAIT))  wait_nxt = wait_cnt + 1'b1;
  end

  // Sticky status flags plus the wait counter register.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      wait_cnt    <= '0;
      starve_o    <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (MAX_WAIT != 0 && waiting && wait_nxt == WAIT_W'(MAX_WAIT)) starve_o <= 1'b1;
      if ((en0_i && !gnt0_o) || (en1_i && !gnt1_o))                  proto_err_o <= 1'b1;
    end
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (IO or DC) between two requesters: port 0 (LoadUnLoad loader) and port 1 (compute engine, e.g. k-means).
- Replaces the ad-hoc start/ready-based combinational BRAM mux in the top level with an explicit req/grant handshake, ownership hold, turnaround drain and read-valid tagging.
- One instance per BRAM; the MstCtrl sequence is unchanged, and requesters only gain a req/gnt pair.

Parameters:
ADDR_W, 32, BRAM address width
DATA_W, 32, BRAM word width
RD_LATENCY, 1, BRAM read latency in cycles (1..4)
MAX_WAIT, 1024, waiting-cycle count that raises starve_o (0 = disabled)

Ports:
Clk  in  1  system clock
ResetN  in  1  synchronous active-low reset; one clock, sampled on rising Clk edge
req0_i, req1_i  in  1  request; held high for the whole ownership period
gnt0_o, gnt1_o  out  1  grant, registered
en0_i, en1_i  in  1  access strobe (read or write) this cycle
we0_i, we1_i  in  1  write enable, qualified by en
addr0_i, addr1_i  in  ADDR_W  access address
wdata0_i, wdata1_i  in  DATA_W  write data
rdata0_o, rdata1_o  out  DATA_W  read data (bram_din_i fanned out)
rvalid0_o, rvalid1_o  out  1  read data valid for that port
bram_addr_o  out  ADDR_W  to BRAM addr
bram_dout_o  out  DATA_W  to BRAM write data
bram_we_o  out  1  to BRAM we
bram_din_i  in  DATA_W  BRAM read data
owner_o  out  2  00 none, 01 port0, 10 port1
starve_o  out  1  sticky: waiting requester exceeded MAX_WAIT
proto_err_o  out  1  sticky: en asserted without grant

Behaviour:
- Reset (ResetN=0 at edge):
  - state=IDLE; gnt*, rvalid*, starve_o and proto_err_o = 0; owner_o=00.
  - last_owner=1, so port 0 wins the first tie.
  - rvalid pipeline cleared.
  - Reset mid-transfer aborts immediately: no further BRAM write, in-flight reads discarded.
- States: IDLE, OWN0, OWN1, DRAIN.
  - IDLE: if only reqN is high -> OWNN. If both are high -> the port != last_owner. gnt is asserted the cycle after req is first sampled (1-cycle grant latency).
  - OWNN: gntN=1 while reqN=1. reqN falling -> DRAIN and gntN=0 on the next edge; last_owner=N.
  - DRAIN: lasts exactly RD_LATENCY cycles (down-counter), then IDLE. No grant during DRAIN. BRAM we forced 0.
  - Requests arriving during DRAIN are arbitrated in IDLE on the following cycle.
- Datapath (combinational from the owner's inputs):
  - In OWNN: bram_addr_o=addrN_i, bram_dout_o=wdataN_i, bram_we_o=enN_i&weN_i.
  - Otherwise: addr=0, dout=0, we=0.
- Reads:
  - A granted en&~we cycle pushes a tag (port id) into an RD_LATENCY-deep shift pipeline.
  - rvalidN_o=1 exactly RD_LATENCY cycles later when the tag=N. rdata0_o=rdata1_o=bram_din_i always.
  - The pipeline keeps shifting through DRAIN, so no read is lost on handover.
- Preemption: none. An owner holds the port until it drops req.
- Starvation:
  - A per-arbiter counter counts cycles a non-owner req has been pending while the other port is owned.
  - When it reaches MAX_WAIT, starve_o=1 (sticky until reset). The counter clears on grant.
- Protocol errors:
  - en asserted on a port without gnt sets proto_err_o=1 (sticky).
  - The access is blocked: no BRAM effect, no rvalid.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises req: DRAIN first, then grant to the other.
  - Same port re-requesting in IDLE against a waiting other port: the other port wins (round-robin).

Decomposition:
- Shared package/header (alongside DataTypes.vh):
  - state encodings ARB_IDLE/ARB_OWN0/ARB_OWN1/ARB_DRAIN
  - owner codes OWNER_NONE/OWNER_P0/OWNER_P1
  - default widths reuse IO_/DC_BRAM_ADDR/WORD_SIZE_BITS_NB
- One natural sub-module: rd_tag_pipe (RD_LATENCY-deep shift register of valid+port tag, synchronous active-low reset).

Test Plan:
- Reset then req0=1 at cycle 2 -> gnt0=1 at cycle 3, owner_o=01; write addr 0x10 data 0xDEADBEEF -> bram_we_o=1, bram_addr_o=0x10 that cycle.
- req0 and req1 both rise at cycle 5 after reset -> gnt0 first. req0 drops -> 1 DRAIN cycle, then gnt1. Next tie after a release by port 1 -> port 0 wins.
- Port1 read at addr 0x4 with BRAM returning 0x1234 (RD_LATENCY=1) -> rvalid1_o=1 with rdata1_o=0x1234 one cycle later; rvalid0_o stays 0. req1 drops the same cycle as the read -> rvalid1 still fires during DRAIN.
- RD_LATENCY=3: owner release -> DRAIN for exactly 3 cycles; a req from the other port during DRAIN is granted on cycle 5 after release.
- en1=1, we1=1 with no grant -> bram_we_o=0, proto_err_o=1 next cycle and stays set; MAX_WAIT=8 with port0 holding 20 cycles while req1 is pending -> starve_o=1 after 8 waiting cycles.
- ResetN=0 mid-ownership with a read in flight -> next cycle gnt*=0, rvalid*=0, owner_o=00, bram_we_o=0.
